// File: rtl/apb_bridge_nslv.sv
// APB master bridge: host command -> APB SETUP/ACCESS towards NUM_SLV one-hot selected slaves.
// Optional access timeout enabled by defining APB_TIMEOUT_EN.
module apb_bridge_nslv #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_SLV = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      transfer,
    input  logic                      READ_WRITE,
    input  logic [ADDR_W-1:0]         write_paddr,
    input  logic [ADDR_W-1:0]         read_paddr,
    input  logic [DATA_W-1:0]         write_data,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR_S,
    output logic [DATA_W-1:0]         read_data,
    output logic                      PSLVERR,
    output logic                      done,
    output logic                      busy
);

    localparam int unsigned SEL_W = $clog2(NUM_SLV);

    if (NUM_SLV < 2 || NUM_SLV > 16 || ADDR_W < SEL_W || TIMEOUT < 1) begin : g_bad_param
        $error("apb_bridge_nslv: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  new_addr;
    logic [SEL_W-1:0]   new_idx;
    logic [NUM_SLV-1:0] new_psel;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               dec_err;
    logic               tmo;
    logic               complete;
    logic               capture;

    logic [NUM_SLV-1:0] psel_d;
    logic               penable_d;
    logic [ADDR_W-1:0]  paddr_d;
    logic               pwrite_d;
    logic [DATA_W-1:0]  pwdata_d;
    logic [DATA_W-1:0]  read_data_d;
    logic               pslverr_d;
    logic               busy_d;

    // Out-of-range index matches no slave, leaving new_psel all-zero (decode error).
    always_comb begin
        new_addr = READ_WRITE ? read_paddr : write_paddr;
        new_idx  = new_addr[ADDR_W-1 -: SEL_W];
        new_psel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            new_psel[i] = (32'(new_idx) == i);
        end
    end

    // Registered PSEL doubles as the return-path mux select; empty PSEL means decode error.
    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (PSEL[i]) begin
                sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
            end
        end
        sel_ready = |(PREADY & PSEL);
        sel_err   = |(PSLVERR_S & PSEL);
        dec_err   = ~|PSEL;
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tmo_cnt <= '0;
        end else if (state == ST_SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ST_ACCESS && !sel_ready) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo = (state == ST_ACCESS) && !dec_err && !sel_ready &&
                 (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    assign complete = (state == ST_ACCESS) && (sel_ready || dec_err || tmo);
    assign capture  = transfer && ((state == ST_IDLE) || complete);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (transfer) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (complete) state_nxt = transfer ? ST_SETUP : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        psel_d      = PSEL;
        paddr_d     = PADDR;
        pwrite_d    = PWRITE;
        pwdata_d    = PWDATA;
        read_data_d = read_data;
        pslverr_d   = PSLVERR;
        penable_d   = (state_nxt == ST_ACCESS);
        busy_d      = (state_nxt != ST_IDLE);

        if (complete) begin
            psel_d    = '0;
            pslverr_d = dec_err | tmo | sel_err;
            if (!PWRITE && !dec_err && !tmo) begin
                read_data_d = sel_rdata;
            end
        end

        if (capture) begin
            psel_d   = new_psel;
            paddr_d  = new_addr;
            pwrite_d = ~READ_WRITE;
            if (!READ_WRITE) begin
                pwdata_d = write_data;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            read_data <= '0;
            PSLVERR   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PADDR     <= paddr_d;
            PWRITE    <= pwrite_d;
            PWDATA    <= pwdata_d;
            read_data <= read_data_d;
            PSLVERR   <= pslverr_d;
            done      <= complete;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Directed bench for apb_bridge_nslv: a 2-slave instance and a 3-slave instance
// sharing clock and reset; expected values are hand-computed constants.
module tb_apb_bridge_nslv;

    logic       PCLK;
    logic       PRESETn;

    // 2-slave instance, ADDR_W=9, slave index = PADDR[8]
    logic       transfer;
    logic       READ_WRITE;
    logic [8:0] write_paddr;
    logic [8:0] read_paddr;
    logic [7:0] write_data;
    logic [1:0] PSEL;
    logic       PENABLE;
    logic [8:0] PADDR;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [15:0] PRDATA;
    logic [1:0] PREADY;
    logic [1:0] PSLVERR_S;
    logic [7:0] read_data;
    logic       PSLVERR;
    logic       done;
    logic       busy;

    // 3-slave instance, ADDR_W=10, slave index = PADDR[9:8]
    logic       d_transfer;
    logic       d_rw;
    logic [9:0] d_wpaddr;
    logic [9:0] d_rpaddr;
    logic [7:0] d_wdata;
    logic [2:0] d_psel;
    logic       d_penable;
    logic [9:0] d_paddr;
    logic       d_pwrite;
    logic [7:0] d_pwdata;
    logic [23:0] d_prdata;
    logic [2:0] d_pready;
    logic [2:0] d_pslverr_s;
    logic [7:0] d_read_data;
    logic       d_pslverr;
    logic       d_done;
    logic       d_busy;

    int checks   = 0;
    int failures = 0;

    apb_bridge_nslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(4)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .write_paddr(write_paddr), .read_paddr(read_paddr), .write_data(write_data),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR_S(PSLVERR_S), .read_data(read_data),
        .PSLVERR(PSLVERR), .done(done), .busy(busy)
    );

    apb_bridge_nslv #(.ADDR_W(10), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(16)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .transfer(d_transfer), .READ_WRITE(d_rw),
        .write_paddr(d_wpaddr), .read_paddr(d_rpaddr), .write_data(d_wdata),
        .PSEL(d_psel), .PENABLE(d_penable), .PADDR(d_paddr), .PWRITE(d_pwrite), .PWDATA(d_pwdata),
        .PRDATA(d_prdata), .PREADY(d_pready), .PSLVERR_S(d_pslverr_s), .read_data(d_read_data),
        .PSLVERR(d_pslverr), .done(d_done), .busy(d_busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // {PSEL, PENABLE, busy, done}
    function automatic logic [4:0] ctl();
        return {PSEL, PENABLE, busy, done};
    endfunction

    task automatic test_reset();
        PRESETn = 1'b0;
        transfer = 1'b0; READ_WRITE = 1'b0; write_paddr = '0; read_paddr = '0; write_data = '0;
        PRDATA = '0; PREADY = '0; PSLVERR_S = '0;
        d_transfer = 1'b0; d_rw = 1'b0; d_wpaddr = '0; d_rpaddr = '0; d_wdata = '0;
        d_prdata = '0; d_pready = '0; d_pslverr_s = '0;
        tick();
        tick();
        checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, read_data, PSLVERR, done, busy} !== 33'd0) begin
            failures++;
            $display("FAIL reset2 got psel=%b en=%b addr=%h pw=%b wd=%h rd=%h err=%b done=%b busy=%b exp all zero",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, read_data, PSLVERR, done, busy);
        end
        checks++;
        if ({d_psel, d_penable, d_paddr, d_pwrite, d_pwdata, d_read_data, d_pslverr, d_done, d_busy} !== 35'd0) begin
            failures++;
            $display("FAIL reset3 got psel=%b en=%b addr=%h rd=%h done=%b busy=%b exp all zero",
                     d_psel, d_penable, d_paddr, d_read_data, d_done, d_busy);
        end
        PRESETn = 1'b1;
        tick();
        checks++;
        if (ctl() !== 5'b00000) begin
            failures++;
            $display("FAIL idle_after_reset got ctl=%b exp 00000", ctl());
        end
    endtask

    task automatic test_write();
        transfer = 1'b1; READ_WRITE = 1'b0; write_paddr = 9'h0A5; read_paddr = 9'h1FF;
        write_data = 8'h3C; PREADY = 2'b11; PSLVERR_S = 2'b00;
        tick();
        transfer = 1'b0; write_data = 8'hEE;
        checks++;
        if (ctl() !== 5'b01010) begin
            failures++;
            $display("FAIL wr_setup got ctl=%b exp 01010", ctl());
        end
        checks++;
        if ({PADDR, PWRITE, PWDATA} !== {9'h0A5, 1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL wr_setup_bus got addr=%h pw=%b wd=%h exp 0a5 1 3c", PADDR, PWRITE, PWDATA);
        end
        tick();
        checks++;
        if (ctl() !== 5'b01110) begin
            failures++;
            $display("FAIL wr_access got ctl=%b exp 01110", ctl());
        end
        tick();
        checks++;
        if ({ctl(), PSLVERR, PWDATA, PADDR} !== {5'b00001, 1'b0, 8'h3C, 9'h0A5}) begin
            failures++;
            $display("FAIL wr_done got ctl=%b err=%b wd=%h addr=%h exp 00001 0 3c 0a5",
                     ctl(), PSLVERR, PWDATA, PADDR);
        end
        tick();
        checks++;
        if (ctl() !== 5'b00000) begin
            failures++;
            $display("FAIL wr_done_pulse got ctl=%b exp 00000", ctl());
        end
    endtask

    task automatic test_read_wait();
        transfer = 1'b1; READ_WRITE = 1'b1; read_paddr = 9'h112; write_paddr = 9'h000;
        PRDATA = {8'h7E, 8'h11}; PREADY = 2'b01; PSLVERR_S = 2'b01;
        tick();
        transfer = 1'b0;
        checks++;
        if ({ctl(), PADDR, PWRITE} !== {5'b10010, 9'h112, 1'b0}) begin
            failures++;
            $display("FAIL rd_setup got ctl=%b addr=%h pw=%b exp 10010 112 0", ctl(), PADDR, PWRITE);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl() !== 5'b10110) begin
                failures++;
                $display("FAIL rd_wait%0d got ctl=%b exp 10110", i, ctl());
            end
            if (i < 3) tick();
        end
        PREADY = 2'b11;
        tick();
        checks++;
        if ({ctl(), read_data, PSLVERR} !== {5'b00001, 8'h7E, 1'b0}) begin
            failures++;
            $display("FAIL rd_done got ctl=%b rd=%h err=%b exp 00001 7e 0", ctl(), read_data, PSLVERR);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        transfer = 1'b1; READ_WRITE = 1'b0; write_paddr = 9'h010; write_data = 8'h55;
        read_paddr = 9'h120; PREADY = 2'b11; PSLVERR_S = 2'b00; PRDATA = {8'hA7, 8'h00};
        tick();
        READ_WRITE = 1'b1;
        checks++;
        if ({ctl(), PADDR} !== {5'b01010, 9'h010}) begin
            failures++;
            $display("FAIL b2b_setup1 got ctl=%b addr=%h exp 01010 010", ctl(), PADDR);
        end
        tick();
        checks++;
        if ({ctl(), PWRITE} !== {5'b01110, 1'b1}) begin
            failures++;
            $display("FAIL b2b_access1 got ctl=%b pw=%b exp 01110 1", ctl(), PWRITE);
        end
        tick();
        transfer = 1'b0;
        checks++;
        if ({ctl(), PADDR, PWRITE, PWDATA} !== {5'b10011, 9'h120, 1'b0, 8'h55}) begin
            failures++;
            $display("FAIL b2b_done1_setup2 got ctl=%b addr=%h pw=%b wd=%h exp 10011 120 0 55",
                     ctl(), PADDR, PWRITE, PWDATA);
        end
        tick();
        checks++;
        if (ctl() !== 5'b10110) begin
            failures++;
            $display("FAIL b2b_access2 got ctl=%b exp 10110", ctl());
        end
        tick();
        checks++;
        if ({ctl(), read_data} !== {5'b00001, 8'hA7}) begin
            failures++;
            $display("FAIL b2b_done2 got ctl=%b rd=%h exp 00001 a7", ctl(), read_data);
        end
        tick();
    endtask

    task automatic test_slave_err();
        transfer = 1'b1; READ_WRITE = 1'b0; write_paddr = 9'h005; write_data = 8'h01;
        PREADY = 2'b11; PSLVERR_S = 2'b01;
        tick();
        transfer = 1'b0;
        tick();
        tick();
        checks++;
        if ({done, PSLVERR} !== 2'b11) begin
            failures++;
            $display("FAIL serr_done got done=%b err=%b exp 1 1", done, PSLVERR);
        end
        PSLVERR_S = 2'b10;
        write_paddr = 9'h006;
        transfer = 1'b1;
        tick();
        transfer = 1'b0;
        checks++;
        if ({done, PSLVERR} !== 2'b01) begin
            failures++;
            $display("FAIL serr_held got done=%b err=%b exp 0 1", done, PSLVERR);
        end
        tick();
        tick();
        checks++;
        if ({done, PSLVERR} !== 2'b10) begin
            failures++;
            $display("FAIL serr_cleared got done=%b err=%b exp 1 0", done, PSLVERR);
        end
        PSLVERR_S = 2'b00;
        tick();
    endtask

    task automatic test_decode_err();
        d_transfer = 1'b1; d_rw = 1'b1; d_rpaddr = 10'h2C4; d_pready = 3'b111;
        d_prdata = {8'h9C, 8'h22, 8'h11};
        tick();
        d_transfer = 1'b0;
        checks++;
        if ({d_psel, d_busy} !== {3'b100, 1'b1}) begin
            failures++;
            $display("FAIL dec_slave2_setup got psel=%b busy=%b exp 100 1", d_psel, d_busy);
        end
        tick();
        tick();
        checks++;
        if ({d_done, d_read_data, d_pslverr} !== {1'b1, 8'h9C, 1'b0}) begin
            failures++;
            $display("FAIL dec_slave2_done got done=%b rd=%h err=%b exp 1 9c 0", d_done, d_read_data, d_pslverr);
        end
        d_transfer = 1'b1; d_rpaddr = 10'h3F0; d_prdata = 24'hFFFFFF;
        tick();
        d_transfer = 1'b0;
        checks++;
        if ({d_psel, d_penable, d_busy, d_done} !== 6'b000010) begin
            failures++;
            $display("FAIL dec_setup got psel=%b en=%b busy=%b done=%b exp 000 0 1 0",
                     d_psel, d_penable, d_busy, d_done);
        end
        tick();
        checks++;
        if ({d_psel, d_penable, d_busy, d_done} !== 6'b000110) begin
            failures++;
            $display("FAIL dec_access got psel=%b en=%b busy=%b done=%b exp 000 1 1 0",
                     d_psel, d_penable, d_busy, d_done);
        end
        tick();
        checks++;
        if ({d_psel, d_penable, d_busy, d_done, d_pslverr, d_read_data} !== {6'b000001, 1'b1, 8'h9C}) begin
            failures++;
            $display("FAIL dec_done got psel=%b en=%b busy=%b done=%b err=%b rd=%h exp 000 0 0 1 1 9c",
                     d_psel, d_penable, d_busy, d_done, d_pslverr, d_read_data);
        end
        tick();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        transfer = 1'b1; READ_WRITE = 1'b1; read_paddr = 9'h1AA;
        PREADY = 2'b00; PRDATA = {8'h33, 8'h33}; PSLVERR_S = 2'b00;
        tick();
        transfer = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ctl() !== 5'b10110) begin
                failures++;
                $display("FAIL tmo_wait%0d got ctl=%b exp 10110", i, ctl());
            end
        end
        tick();
        checks++;
        if ({ctl(), PSLVERR, read_data} !== {5'b00001, 1'b1, 8'hA7}) begin
            failures++;
            $display("FAIL tmo_done got ctl=%b err=%b rd=%h exp 00001 1 a7", ctl(), PSLVERR, read_data);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        transfer = 1'b1; READ_WRITE = 1'b1; read_paddr = 9'h1AA;
        PREADY = 2'b00; PRDATA = {8'h33, 8'h44}; PSLVERR_S = 2'b00;
        tick();
        transfer = 1'b0;
        repeat (12) tick();
        checks++;
        if (ctl() !== 5'b10110) begin
            failures++;
            $display("FAIL notmo_wait got ctl=%b exp 10110", ctl());
        end
        PREADY = 2'b10;
        tick();
        checks++;
        if ({ctl(), PSLVERR, read_data} !== {5'b00001, 1'b0, 8'h33}) begin
            failures++;
            $display("FAIL notmo_done got ctl=%b err=%b rd=%h exp 00001 0 33", ctl(), PSLVERR, read_data);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        transfer = 1'b1; READ_WRITE = 1'b0; write_paddr = 9'h0F0; write_data = 8'h99;
        PREADY = 2'b00;
        tick();
        transfer = 1'b0;
        tick();
        checks++;
        if (ctl() !== 5'b01110) begin
            failures++;
            $display("FAIL rst_mid_access got ctl=%b exp 01110", ctl());
        end
        PRESETn = 1'b0;
        PREADY = 2'b11;
        tick();
        checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, read_data, PSLVERR, done, busy} !== 33'd0) begin
            failures++;
            $display("FAIL rst_mid got psel=%b en=%b addr=%h pw=%b wd=%h rd=%h err=%b done=%b busy=%b exp all zero",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, read_data, PSLVERR, done, busy);
        end
        PRESETn = 1'b1;
        tick();
        checks++;
        if (ctl() !== 5'b00000) begin
            failures++;
            $display("FAIL rst_mid_nodone got ctl=%b exp 00000", ctl());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_slave_err();
        test_decode_err();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
